// File: rtl/calc_pkg.sv
// Shared types and constants for the 2-bit signed calculator display path.
package calc_pkg;

   localparam int RES_W = 4;
   localparam int MAG_W = 3;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {
      S_MAG,
      S_GAP0,
      S_SIGN,
      S_GAP1
   } scan_state_t;

   typedef struct packed {
      logic             z;
      logic [RES_W-1:0] res;
   } held_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 3-bit magnitude to active-low {g,f,e,d,c,b,a} segment decoder.
module seg7_decode
   import calc_pkg::*;
(
   input  logic [MAG_W-1:0] mag,
   output logic [6:0]       seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (mag)
         3'd0: seg = 7'b1000000;
         3'd1: seg = 7'b1111001;
         3'd2: seg = 7'b0100100;
         3'd3: seg = 7'b0110000;
         3'd4: seg = 7'b0011001;
         3'd5: seg = 7'b0010010;
         3'd6: seg = 7'b0000010;
         3'd7: seg = 7'b1111000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/res_display.sv
// Holds the sign-magnitude result and scans it onto a two-digit common-anode display.
// Optional post-load blinking is enabled by defining DISP_BLINK_EN.
module res_display
   import calc_pkg::*;
#(
   parameter int REFRESH_DIV   = 50000,
   parameter int BLINK_PERIODS = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [RES_W-1:0] i_res,
   input  logic             i_Z,
   input  logic             i_load,
   output logic [6:0]       o_seg,
   output logic [1:0]       o_an
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   scan_state_t      state_reg;
   logic [CNT_W-1:0] cnt_reg;
   held_t            held_reg;
   logic [6:0]       seg_reg;
   logic [1:0]       an_reg;
   logic [MAG_W-1:0] mag_sel;
   logic [6:0]       mag_seg;
   logic             sign_on;
   logic             blink_off;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         held_reg <= '{z: 1'b1, res: '0};
      end else if (i_load) begin
         held_reg <= '{z: i_Z, res: i_res};
      end
   end

   // A zero result never shows a sign or a non-zero magnitude.
   assign mag_sel = held_reg.z ? '0 : held_reg.res[MAG_W-1:0];
   assign sign_on = held_reg.res[RES_W-1] & ~held_reg.z;

   seg7_decode u_decode (
      .mag (mag_sel),
      .seg (mag_seg)
   );

`ifdef DISP_BLINK_EN
   localparam int PER_LEN = 2 * REFRESH_DIV + 2;
   localparam int PCYC_W  = $clog2(PER_LEN);
   localparam int PNUM_W  = $clog2(BLINK_PERIODS + 1);
   localparam logic [PCYC_W-1:0] PCYC_LAST = PCYC_W'(PER_LEN - 1);
   localparam logic [PNUM_W-1:0] PNUM_LAST = PNUM_W'(BLINK_PERIODS);

   logic [PCYC_W-1:0] blink_cyc_reg;
   logic [PNUM_W-1:0] blink_num_reg;

   // blink_num_reg is the 1-based period index since the last load; 0 means idle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         blink_cyc_reg <= '0;
         blink_num_reg <= '0;
      end else if (i_load) begin
         blink_cyc_reg <= '0;
         blink_num_reg <= PNUM_W'(1);
      end else if (blink_num_reg != '0) begin
         if (blink_cyc_reg == PCYC_LAST) begin
            blink_cyc_reg <= '0;
            blink_num_reg <= (blink_num_reg == PNUM_LAST) ? '0 : blink_num_reg + 1'b1;
         end else begin
            blink_cyc_reg <= blink_cyc_reg + 1'b1;
         end
      end
   end

   assign blink_off = blink_num_reg[0];
`else
   logic [31:0] blink_unused;
   assign blink_unused = 32'(BLINK_PERIODS);
   assign blink_off    = 1'b0;
`endif

   // Outputs are registered from the current state, so they trail it by one edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= S_MAG;
         cnt_reg   <= '0;
         seg_reg   <= SEG_BLANK;
         an_reg    <= 2'b11;
      end else begin
         case (state_reg)
            S_MAG: begin
               seg_reg <= mag_seg;
               an_reg  <= blink_off ? 2'b11 : 2'b10;
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= S_GAP0;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_SIGN: begin
               seg_reg <= sign_on ? SEG_MINUS : SEG_BLANK;
               an_reg  <= blink_off ? 2'b11 : 2'b01;
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= S_GAP1;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_GAP0: begin
               seg_reg   <= SEG_BLANK;
               an_reg    <= 2'b11;
               state_reg <= S_SIGN;
               cnt_reg   <= '0;
            end
            default: begin
               seg_reg   <= SEG_BLANK;
               an_reg    <= 2'b11;
               state_reg <= S_MAG;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   assign o_seg = seg_reg;
   assign o_an  = an_reg;

endmodule

// File: tb/tb_res_display.sv
// Self-checking bench for res_display: directed and random loads against a scan-position model.
module tb_res_display;

   localparam int DIV   = 4;
   localparam int BLINK = 2;
   localparam int PER   = 2 * DIV + 2;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [3:0] i_res;
   logic       i_Z;
   logic       i_load;
   logic [6:0] o_seg;
   logic [1:0] o_an;

   int compared   = 0;
   int mismatched = 0;

   // Model state: edges since reset release, held value, edge of the last load.
   int         n;
   logic       m_z;
   logic [3:0] m_res;
   int         last_load;

   logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

   always #5 i_clk = ~i_clk;

   res_display #(
      .REFRESH_DIV   (DIV),
      .BLINK_PERIODS (BLINK)
   ) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_res  (i_res),
      .i_Z    (i_Z),
      .i_load (i_load),
      .o_seg  (o_seg),
      .o_an   (o_an)
   );

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s edge=%0d: observed %b expected %b", tag, n, got, exp);
      end
   endtask

   task automatic model_reset();
      n         = 0;
      m_z       = 1'b1;
      m_res     = 4'b0000;
      last_load = -1;
   endtask

   task automatic step(input logic ld, input logic [3:0] res, input logic z);
      logic [6:0] e_seg;
      logic [1:0] e_an;
      int p;
      int d;
      int idx;
      i_load = ld;
      i_res  = res;
      i_Z    = z;
      @(posedge i_clk);
      n++;
      p = (n - 1) % PER;
      if (p < DIV) begin
         idx   = m_z ? 0 : int'(m_res[2:0]);
         e_an  = 2'b10;
         e_seg = seg_tab[idx];
      end else if (p > DIV && p <= 2 * DIV) begin
         e_an  = 2'b01;
         e_seg = (m_res[3] && !m_z) ? 7'b0111111 : 7'b1111111;
      end else begin
         e_an  = 2'b11;
         e_seg = 7'b1111111;
      end
`ifdef DISP_BLINK_EN
      if (last_load >= 0) begin
         d = n - last_load - 1;
         if ((d / PER) < BLINK && ((d / PER) % 2) == 0) e_an = 2'b11;
      end
`endif
      if (ld) begin
         m_z       = z;
         m_res     = res;
         last_load = n;
         $display("load res=%b z=%b at edge %0d", res, z, n);
      end
      #1;
      check("an", {5'b0, o_an}, {5'b0, e_an});
      check("seg", o_seg, e_seg);
      i_load = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 4'b0000, 1'b0);
   endtask

   task automatic async_reset(input string tag);
      #3 i_rst = 1'b1;
      #1;
      check({tag, "_an"}, {5'b0, o_an}, 7'b0000011);
      check({tag, "_seg"}, o_seg, 7'h7F);
      @(posedge i_clk);
      #1;
      check({tag, "_an_hold"}, {5'b0, o_an}, 7'b0000011);
      i_rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      i_rst  = 1'b0;
      i_load = 1'b0;
      i_res  = 4'b0000;
      i_Z    = 1'b0;
      model_reset();

      // Power-on reset, then first edge shows magnitude digit '0'.
      #2 i_rst = 1'b1;
      #1;
      check("por_an", {5'b0, o_an}, 7'b0000011);
      check("por_seg", o_seg, 7'h7F);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      model_reset();
      idle(7);

      // Reset mid-scan.
      async_reset("rst_mid");
      idle(3);

      // Negative five: '5' on magnitude, '-' on sign, 1-cycle gaps.
      step(1'b1, 4'b1101, 1'b0);
      idle(22);

      // Negative zero is suppressed.
      step(1'b1, 4'b1000, 1'b1);
      idle(12);

      // Back-to-back loads landing in the sign phase; last one wins.
      for (int i = 0; i < PER && (n % PER) != DIV + 1; i++) idle(1);
      step(1'b1, 4'b0011, 1'b0);
      step(1'b1, 4'b0110, 1'b0);
      idle(12);

      // Blink sequence, restarted by a reload mid-blink.
      step(1'b1, 4'b0010, 1'b0);
      idle(14);
      step(1'b1, 4'b1010, 1'b0);
      idle(26);

      // Reset mid-blink clears everything, no blink afterwards.
      step(1'b1, 4'b1110, 1'b0);
      idle(3);
      async_reset("rst_blink");
      idle(12);

      // Every magnitude through the decoder.
      for (int m = 0; m < 8; m++) begin
         step(1'b1, 4'(m), 1'b0);
         idle(PER);
      end

      // Random loads.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0)
            step(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         else
            idle(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/res_display.md
# res_display

Downstream consumer of the signed add/sub stage in the 2-bit signed calculator. Captures the 4-bit sign-magnitude result (bit 3 = sign, bits 2:0 = magnitude) and its zero flag on a load strobe, then drives a two-digit, time-multiplexed, common-anode 7-segment display. The sign digit shows `-` or blank, and the magnitude digit shows 0–7. Segment and anode outputs are registered and scanned by an internal refresh FSM with a dead-time gap between digits to prevent ghosting.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit; legal range ≥ 2.
- `BLINK_PERIODS`, default 8: full scan cycles of post-load blinking; used only with `DISP_BLINK_EN`.
- `i_clk` input, 1: the single clock; all state changes on its rising edge.
- `i_rst` input, 1: reset, asynchronous and active-high.
- `i_res` input, 4: sign-magnitude result from the add/sub stage.
- `i_Z` input, 1: zero-result flag from the add/sub stage.
- `i_load` input, 1: capture strobe, sampled every rising edge.
- `o_seg` output, 7: segments {g,f,e,d,c,b,a}, active-low.
- `o_an` output, 2: digit anodes, active-low; [0] = magnitude digit, [1] = sign digit.

## Operation
- Capture: when `i_load` = 1 at a rising edge, the held register takes `{i_Z, i_res}`. Otherwise it holds. A load every cycle is legal; the last one wins.
- Negative-zero suppression: if the held Z = 1, the sign digit is blank regardless of the held sign bit. The magnitude digit shows `0`.
- Sign digit: shows `-` (segment g only, `o_seg` = 7'b0111111) when sign = 1 and Z = 0. Otherwise it is blank (7'b1111111).
- Magnitude digit: standard decode of 0–7. The value 7 never comes from the add/sub stage but is still decoded.
- Scan FSM states and transitions:
  - `S_MAG` → `S_GAP0` after `REFRESH_DIV` cycles.
  - `S_GAP0` → `S_SIGN` after 1 cycle.
  - `S_SIGN` → `S_GAP1` after `REFRESH_DIV` cycles.
  - `S_GAP1` → `S_MAG` after 1 cycle.
- Per-state outputs:
  - `S_MAG`: `o_an` = 2'b10.
  - `S_SIGN`: `o_an` = 2'b01.
  - Gap states: `o_an` = 2'b11 and `o_seg` = 7'b1111111.
- Refresh counter: runs 0 to `REFRESH_DIV`-1 in `S_MAG` and `S_SIGN`. It clears on every state change and wraps to 0 on the exit transition.
- Loads do not disturb the scan FSM or the refresh counter.

## Timing
- Reset values:
  - State `S_MAG`, counter 0.
  - Held register = {Z=1, res=4'b0000}.
  - `o_seg` = 7'b1111111, `o_an` = 2'b11.
- After reset release: the first rising edge drives `S_MAG` outputs, so `o_an` = 2'b10 and `o_seg` = `0` (7'b1000000).
- Load latency: a load at edge k updates the held register at k. The outputs of the active digit reflect it at edge k+1.
- One full scan period = 2·`REFRESH_DIV` + 2 cycles.
- Reset mid-scan or mid-blink: all state returns to reset values immediately (asynchronously). The displayed value is lost.
- A load coinciding with a state transition: both take effect. The new digit shows the new value one edge later.

## Configuration
- Macro: `DISP_BLINK_EN`.
- Defined:
  - Each load (re)starts a blink counter of `BLINK_PERIODS` scan periods. A load during blinking restarts it.
  - During odd-numbered periods (1, 3, …) `o_an` is forced to 2'b11.
  - Blinking ends after the last period and the display returns to steady.
  - Reset clears the blink counter to idle, so there is no blink after reset.
- Undefined: no blink counter logic exists, and the display is always steady.

## Structure
- Shared package `calc_pkg` holds:
  - the scan state enum (`S_MAG`, `S_GAP0`, `S_SIGN`, `S_GAP1`);
  - segment constants `SEG_BLANK`, `SEG_MINUS`;
  - the result field widths (4-bit result, 3-bit magnitude).
- One sub-module, `seg7_decode`: purely combinational, 3-bit magnitude in → 7-bit active-low segments out.
- `seg7_decode` is instantiated once. Its output is registered in `res_display`.

## Test plan
Run with `REFRESH_DIV` = 4 and `BLINK_PERIODS` = 2.
1. Reset asserted mid-scan → `o_an` = 2'b11 and `o_seg` = 7'h7F immediately. After release, the first edge gives `o_an` = 2'b10 and `o_seg` = 7'b1000000.
2. Load `i_res` = 4'b1101, `i_Z` = 0:
   - magnitude phase: `o_seg` = 7'b0010010 (`5`);
   - sign phase: 7'b0111111;
   - gaps last exactly 1 cycle each with all outputs off;
   - scan period is 10 cycles.
3. Load `i_res` = 4'b1000, `i_Z` = 1 → sign digit blank, magnitude digit shows `0`.
4. Load 4'b0011 at edge k during `S_SIGN`, then load 4'b0110 at edge k+1 → the next magnitude phase shows `6` (7'b0000010), and the sign digit stays blank.
5. With `DISP_BLINK_EN` defined: load 4'b0010 → anodes stay off for scan period 1 (10 cycles), scan normally in period 2, then remain steady. A reload mid-blink restarts the sequence.
6. Check each magnitude 0–7 via loads: decoded `o_seg` matches the standard active-low table.
